// File: rtl/stage_seq_ctrl.sv
// Stage sequencer: a 4-phase left/right handshake per instruction, with a latch-then-request
// pass over the class-enabled datapath stages. Optional retire counter: SEQ_INSTR_COUNT_EN.
module stage_seq_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int PULSE_W    = 2,
    parameter int CLASS_W    = 2,
    parameter logic [NUM_STAGES*(2**CLASS_W)-1:0] MASK_TABLE = 16'h9_9_F_F,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  _rst,
    input  logic                  lr,
    output logic                  la,
    input  logic [CLASS_W-1:0]    cls,
    output logic                  rr,
    input  logic                  ra,
    output logic [NUM_STAGES-1:0] _latch,
    output logic [NUM_STAGES-1:0] stage_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic                  busy
`ifdef SEQ_INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0]      instr_cnt
`endif
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(PULSE_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        REQ,
        RELEASE,
        OUT_REQ,
        OUT_REL,
        ACK
    } stateT;

    stateT                 state, stateNext;
    logic [SW-1:0]         stage, stageNext;
    logic [CW-1:0]         cnt, cntNext;
    logic [NUM_STAGES-1:0] maskQ, maskNext;
    logic [NUM_STAGES-1:0] maskSel;
    logic [SW-1:0]         lowestStage, higherStage;
    logic                  higherAny;
    logic [NUM_STAGES-1:0] latchNext, reqNext;

    // Class mask lookup plus two priority encoders: the first enabled stage of the
    // incoming class, and the next enabled stage above the one just finished.
    always_comb begin
        maskSel     = MASK_TABLE[int'(cls)*NUM_STAGES +: NUM_STAGES];
        lowestStage = '0;
        higherStage = '0;
        higherAny   = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (maskSel[i]) begin
                lowestStage = SW'(i);
            end
            if (maskQ[i] && (i > int'(stage))) begin
                higherStage = SW'(i);
                higherAny   = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        stageNext = stage;
        cntNext   = cnt;
        maskNext  = maskQ;
        unique case (state)
            IDLE: begin
                if (lr && !ra) begin
                    maskNext = maskSel;
                    cntNext  = CNT_RELOAD;
                    if (maskSel == '0) begin
                        stateNext = OUT_REQ;
                    end else begin
                        stageNext = lowestStage;
                        stateNext = LATCH;
                    end
                end
            end
            LATCH: begin
                if (cnt == '0) begin
                    stateNext = REQ;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            REQ: begin
                if (stage_ack[stage]) begin
                    stateNext = RELEASE;
                end
            end
            RELEASE: begin
                if (!stage_ack[stage]) begin
                    if (higherAny) begin
                        stageNext = higherStage;
                        cntNext   = CNT_RELOAD;
                        stateNext = LATCH;
                    end else begin
                        stateNext = OUT_REQ;
                    end
                end
            end
            OUT_REQ: begin
                if (ra) begin
                    stateNext = OUT_REL;
                end
            end
            OUT_REL: begin
                if (!ra) begin
                    stateNext = ACK;
                end
            end
            ACK: begin
                if (!lr) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered alongside it.
    always_comb begin
        latchNext = '0;
        reqNext   = '0;
        if (stateNext == LATCH) begin
            latchNext[stageNext] = 1'b1;
        end
        if (stateNext == REQ) begin
            reqNext[stageNext] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            stage     <= '0;
            cnt       <= '0;
            maskQ     <= '0;
            _latch    <= '0;
            stage_req <= '0;
            la        <= 1'b0;
            rr        <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            stage     <= stageNext;
            cnt       <= cntNext;
            maskQ     <= maskNext;
            _latch    <= latchNext;
            stage_req <= reqNext;
            la        <= (stateNext == ACK);
            rr        <= (stateNext == OUT_REQ);
            busy      <= (stateNext != IDLE);
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    // One instruction retires on the ACK->IDLE edge; the count wraps naturally.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            instr_cnt <= '0;
        end else if (state == ACK && !lr) begin
            instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Randomized scoreboard bench for stage_seq_ctrl; expected stage/retire order comes from the
// class masks, and a monitor checks the DUT's pulses against it.
module tb_stage_seq_ctrl;

    localparam int NUM_ST  = 4;
    localparam int PULSE   = 2;
    localparam int CNTW    = 2;
    localparam logic [15:0] MODEL_MASK = 16'h99FF;
    localparam int RETIRE  = NUM_ST;

    logic              clk = 1'b0;
    logic              rstN;
    logic              lr;
    logic              la;
    logic [1:0]        cls;
    logic              rr;
    logic              ra;
    logic [NUM_ST-1:0] latchOut;
    logic [NUM_ST-1:0] stageReq;
    logic [NUM_ST-1:0] stageAck;
    logic              busy;
`ifdef SEQ_INSTR_COUNT_EN
    logic [CNTW-1:0]   instrCnt;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    int expQ[$];
    bit respEn    = 1'b0;
    bit manualAck = 1'b0;
    bit noiseEn   = 1'b0;

    stage_seq_ctrl #(.CNT_W(CNTW)) dut (
        .clk       (clk),
        ._rst      (rstN),
        .lr        (lr),
        .la        (la),
        .cls       (cls),
        .rr        (rr),
        .ra        (ra),
        ._latch    (latchOut),
        .stage_req (stageReq),
        .stage_ack (stageAck),
        .busy      (busy)
`ifdef SEQ_INSTR_COUNT_EN
        ,
        .instr_cnt (instrCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: a class retires after its enabled stages, in ascending order.
    task automatic pushExpected(input int c);
        logic [3:0] m;
        m = 4'((MODEL_MASK >> (c * 4)) & 16'hF);
        for (int k = 0; k < NUM_ST; k++) begin
            if (m[k]) expQ.push_back(k);
        end
        expQ.push_back(RETIRE);
    endtask

    task automatic waitLaAndDrop();
        int n = 0;
        while (!la && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!la) checkOutput("laTimeout", 0, 1);
        lr = 1'b0;
    endtask

    task automatic applyStimulus(input int c);
        int n = 0;
        while ((busy || la) && n < 500) begin
            @(negedge clk);
            n++;
        end
        cls = 2'(c);
        lr  = 1'b1;
        pushExpected(c);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 500);
        if (!busy) checkOutput("acceptTimeout", 0, 1);
        cls = 2'($urandom);
        waitLaAndDrop();
    endtask

    // Stage responder: acks follow stage_req with random lag, plus optional noise on other bits.
    initial begin
        forever begin
            @(negedge clk);
            if (respEn && !manualAck) begin
                if (stageReq != '0) begin
                    if ($urandom_range(0, 2) != 0) stageAck = stageReq;
                end else if ($urandom_range(0, 1) != 0) begin
                    stageAck = '0;
                end
                if (noiseEn) stageAck = stageAck | (4'($urandom) & ~stageReq & 4'($urandom));
            end
        end
    end

    // Right-side responder with random ra latency.
    initial begin
        forever begin
            @(negedge clk);
            if (respEn) begin
                if (rr && !ra && $urandom_range(0, 1) != 0) ra = 1'b1;
                else if (!rr && ra && $urandom_range(0, 1) != 0) ra = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each latch pulse and each retire request.
    initial begin
        logic [NUM_ST-1:0] prevLatch;
        logic              prevRr, prevLa;
        int                latchLen, retired, got, exp;
        prevLatch = '0; prevRr = 0; prevLa = 0; latchLen = 0; retired = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prevLatch = '0; prevRr = 0; prevLa = 0; latchLen = 0; retired = 0;
                continue;
            end
            checkOutput("oneHot", int'($countones(latchOut | stageReq) <= 1), 1);
            if (latchOut != '0 && prevLatch == '0) begin
                got = -1;
                for (int k = NUM_ST - 1; k >= 0; k--) if (latchOut[k]) got = k;
                exp = (expQ.size() > 0) ? expQ.pop_front() : -1;
                checkOutput("latchStage", got, exp);
                latchLen = 1;
            end else if (latchOut != '0) begin
                latchLen++;
            end else if (prevLatch != '0) begin
                checkOutput("latchWidth", latchLen, PULSE);
                checkOutput("reqAfterLatch", int'(stageReq), int'(prevLatch));
            end
            if (rr && !prevRr) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : -1;
                checkOutput("retireOrder", RETIRE, exp);
            end
            if (la && !prevLa) begin
                checkOutput("laAfterRaLow", int'({rr, ra}), 0);
            end
            if (!la && prevLa) begin
                retired++;
                checkOutput("busyAfterAck", int'(busy), 0);
`ifdef SEQ_INSTR_COUNT_EN
                checkOutput("instrCnt", int'(instrCnt), retired % (1 << CNTW));
`endif
            end
            prevLatch = latchOut;
            prevRr    = rr;
            prevLa    = la;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rstN = 1'b0; lr = 1'b1; cls = 2'd0; ra = 1'b1; stageAck = 4'hF;
        pushExpected(0);
        repeat (3) @(negedge clk);
        checkOutput("rstLa", int'(la), 0);
        checkOutput("rstRr", int'(rr), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstLatch", int'(latchOut), 0);
        checkOutput("rstReq", int'(stageReq), 0);
`ifdef SEQ_INSTR_COUNT_EN
        checkOutput("rstCnt", int'(instrCnt), 0);
`endif
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("raBlocksAccept", int'(busy), 0);
        ra = 1'b0; stageAck = '0;
        @(negedge clk);
        checkOutput("firstLatch", int'(latchOut), 1);
        respEn = 1'b1;
        waitLaAndDrop();

        applyStimulus(0);
        applyStimulus(2);
        applyStimulus(3);
        noiseEn = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus(int'($urandom_range(0, 3)));
        noiseEn = 1'b0;

        // Held ack on stage 1 stalls RELEASE until it drops.
        n = 0;
        while ((busy || la) && n < 500) begin @(negedge clk); n++; end
        cls = 2'd0; lr = 1'b1; pushExpected(0);
        n = 0;
        while (!stageReq[1] && n < 500) begin @(negedge clk); n++; end
        checkOutput("reachReq1", int'(stageReq[1]), 1);
        manualAck = 1'b1; stageAck = 4'b0010;
        @(negedge clk);
        repeat (3) begin
            checkOutput("stallLatch2", int'(latchOut[2]), 0);
            checkOutput("stallBusy", int'(busy), 1);
            checkOutput("stallReq", int'(stageReq), 0);
            @(negedge clk);
        end
        stageAck = '0;
        @(negedge clk);
        checkOutput("releaseToLatch2", int'(latchOut), 4);
        manualAck = 1'b0;
        waitLaAndDrop();

        // Reset mid-REQ of stage 2, then restart.
        n = 0;
        while ((busy || la) && n < 500) begin @(negedge clk); n++; end
        cls = 2'd0; lr = 1'b1; pushExpected(0);
        n = 0;
        while (!stageReq[2] && n < 500) begin @(negedge clk); n++; end
        checkOutput("reachReq2", int'(stageReq[2]), 1);
        rstN = 1'b0;
        #1;
        checkOutput("midRstReq", int'(stageReq), 0);
        checkOutput("midRstLatch", int'(latchOut), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        lr = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(int'($urandom_range(0, 3)));

        repeat (4) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
